// File: rtl/pc_gen.sv
// Fetch-stage PC generator: selects the next PC and steers returns through a circular RAS.
module pc_gen #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [2:0]                   npc_sel,
    input  logic [31:0]                  d_pc,
    input  logic [25:0]                  imm,
    input  logic                         cond,
    input  logic                         link,
    input  logic                         ret,
    input  logic [31:0]                  ra,
    input  logic                         ra_valid,
    input  logic                         fix_valid,
    input  logic [31:0]                  fix_pc,
    output logic [31:0]                  pc,
    output logic [31:0]                  npc,
    output logic                         ras_stall,
    output logic                         ras_empty,
    output logic                         ras_full,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        PC_ADD_4  = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JUMP   = 3'd2,
        PC_REG    = 3'd3,
        PC_EXC    = 3'd4
    } npc_sel_e;

    logic [31:0]   pc_q;
    logic [31:0]   rasMem_q [RAS_DEPTH];
    logic [PW-1:0] rasPtr_q, rasPtr_d;
    logic [CW-1:0] rasCount_q, rasCount_d;

    logic [31:0]   pcPlus4, branchTarget, jumpTarget, rasTop, pushVal;
    logic          rasIsEmpty, rasIsFull, doPush, doPop, regStall;

    always_comb begin
        pcPlus4      = pc_q + 32'd4;
        branchTarget = d_pc + 32'd4 + {{14{imm[15]}}, imm[15:0], 2'b00};
        jumpTarget   = {d_pc[31:28], imm, 2'b00};
        pushVal      = d_pc + 32'd8;
        rasTop       = rasMem_q[rasPtr_q];
        rasIsEmpty   = (rasCount_q == '0);
        rasIsFull    = (rasCount_q == CW'(RAS_DEPTH));
    end

    always_comb begin
        npc      = pcPlus4;
        regStall = 1'b0;
        doPush   = 1'b0;
        doPop    = 1'b0;
        if (fix_valid) begin
            npc = fix_pc;
        end else if (stall) begin
            npc = pc_q;
        end else begin
            case (npc_sel)
                PC_BRANCH: npc = cond ? branchTarget : pcPlus4;
                PC_JUMP: begin
                    npc    = jumpTarget;
                    doPush = link;
                end
                PC_REG: begin
                    if (ra_valid) begin
                        npc = ra;
                    end else if (!rasIsEmpty) begin
                        npc = rasTop;
                    end else begin
                        npc      = pc_q;
                        regStall = 1'b1;
                    end
                    doPop = ret && !regStall;
                end
                PC_EXC:  npc = EXC_VEC;
                default: npc = pcPlus4;
            endcase
        end
    end

    // Popping an empty stack leaves pointer and count alone; pushing a full one wraps over the oldest.
    always_comb begin
        rasPtr_d   = rasPtr_q;
        rasCount_d = rasCount_q;
        if (doPush) begin
            rasPtr_d = rasPtr_q + 1'b1;
            if (!rasIsFull) begin
                rasCount_d = rasCount_q + 1'b1;
            end
        end else if (doPop && !rasIsEmpty) begin
            rasPtr_d   = rasPtr_q - 1'b1;
            rasCount_d = rasCount_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            rasPtr_q   <= '0;
            rasCount_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                rasMem_q[i] <= '0;
            end
        end else begin
            pc_q       <= npc;
            rasPtr_q   <= rasPtr_d;
            rasCount_q <= rasCount_d;
            if (doPush) begin
                rasMem_q[rasPtr_d] <= pushVal;
            end
        end
    end

    assign pc        = pc_q;
    assign ras_stall = regStall && reset;
    assign ras_empty = rasIsEmpty;
    assign ras_full  = rasIsFull;
    assign ras_count = rasCount_q;

endmodule
